// File: rtl/core_pkg.sv
// Shared core definitions: hazard FSM states, register address width,
// stall-length constants and a small dependence-match helper.
package core_pkg;

  localparam int REG_ADDR_W = 5;

  // Stall lengths, in cycles, for the two load-dependence cases.
  localparam logic [1:0] LOAD_USE_STALL  = 2'd1;
  localparam logic [1:0] LOAD_COMP_STALL = 2'd2;

  typedef enum logic [0:0] {
    S_RUN   = 1'b0,
    S_STALL = 1'b1
  } hz_state_e;

  // A producer rd creates a dependence only when it is not x0 and the
  // consumer actually reads the matching source register.
  function automatic logic dep_match(
    input logic [REG_ADDR_W-1:0] rd,
    input logic [REG_ADDR_W-1:0] rs,
    input logic                  rs_used
  );
    dep_match = (rd != {REG_ADDR_W{1'b0}}) && (rd == rs) && rs_used;
  endfunction

endpackage

// File: rtl/hazard_need_calc.sv
// Combinational dependence matcher and stall-requirement encoder.
// Produces how many stall cycles the ID instruction needs against the
// producers currently in EX and ME.
module hazard_need_calc
  import core_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  input  logic                  comp,
  input  logic                  reg_write_ex,
  input  logic                  mem_read_ex,
  input  logic [REG_ADDR_W-1:0] rd_addr_ex,
  input  logic                  mem_read_me,
  input  logic [REG_ADDR_W-1:0] rd_addr_me,
  output logic [1:0]            need
);

  logic m_ex_s;
  logic m_me_s;

  assign m_ex_s = dep_match(rd_addr_ex, rs1_addr, rs1_used) |
                  dep_match(rd_addr_ex, rs2_addr, rs2_used);
  assign m_me_s = dep_match(rd_addr_me, rs1_addr, rs1_used) |
                  dep_match(rd_addr_me, rs2_addr, rs2_used);

  // Take the largest stall length among the rules that fire.
  always_comb begin
    need = 2'd0;
    if (mem_read_ex && m_ex_s && comp) begin
      // Load result needed by the ID comparator: wait until it reaches WB.
      need = LOAD_COMP_STALL;
    end else if ((mem_read_ex && m_ex_s) ||
                 (reg_write_ex && !mem_read_ex && m_ex_s && comp) ||
                 (mem_read_me && m_me_s && comp)) begin
      need = LOAD_USE_STALL;
    end else begin
      need = 2'd0;
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard stall controller. Stalls/bubbles for dependences that
// forwarding cannot cover, freezes on data-memory wait, flushes IF/ID on
// redirect, and counts hazard-stall cycles.
module hazard_stall_ctrl
  import core_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rs1_addr_ID_i,
  input  logic [REG_ADDR_W-1:0] rs2_addr_ID_i,
  input  logic                  rs1_used_ID_i,
  input  logic                  rs2_used_ID_i,
  input  logic                  comp_ID_i,
  input  logic                  redirect_ID_i,
  input  logic                  RegWrite_EX_i,
  input  logic                  MemRead_EX_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_EX_i,
  input  logic                  MemRead_ME_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_ME_i,
  input  logic                  dm_wait_i,
  output logic                  PC_write_o,
  output logic                  IFID_write_o,
  output logic                  IDEX_bubble_o,
  output logic                  IFID_flush_o,
  output logic                  freeze_o,
  output logic [CNT_W-1:0]      stall_cycles_o
);

  hz_state_e        state_r;
  logic [1:0]       cnt_r;
  logic [CNT_W-1:0] stall_cycles_r;
  logic [1:0]       need_s;

  hazard_need_calc u_need (
    .rs1_addr     (rs1_addr_ID_i),
    .rs2_addr     (rs2_addr_ID_i),
    .rs1_used     (rs1_used_ID_i),
    .rs2_used     (rs2_used_ID_i),
    .comp         (comp_ID_i),
    .reg_write_ex (RegWrite_EX_i),
    .mem_read_ex  (MemRead_EX_i),
    .rd_addr_ex   (rd_addr_EX_i),
    .mem_read_me  (MemRead_ME_i),
    .rd_addr_me   (rd_addr_ME_i),
    .need         (need_s)
  );

  assign stall_cycles_o = stall_cycles_r;

  // Pipeline-register controls, decided in the same cycle from state and inputs.
  always_comb begin
    PC_write_o    = 1'b1;
    IFID_write_o  = 1'b1;
    IDEX_bubble_o = 1'b0;
    IFID_flush_o  = 1'b0;
    freeze_o      = 1'b0;
    if (rst) begin
      // Reset presents a free-running pipeline.
      PC_write_o = 1'b1;
    end else if (dm_wait_i) begin
      freeze_o     = 1'b1;
      PC_write_o   = 1'b0;
      IFID_write_o = 1'b0;
    end else if ((state_r == S_STALL) || (need_s != 2'd0)) begin
      // Redirect is ignored here: ID operands are not valid yet, and the
      // held ID instruction presents it again once the stall ends.
      PC_write_o    = 1'b0;
      IFID_write_o  = 1'b0;
      IDEX_bubble_o = 1'b1;
    end else begin
      IFID_flush_o = redirect_ID_i;
    end
  end

  // Stall FSM, remaining-cycle count and stall-cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= S_RUN;
      cnt_r          <= 2'd0;
      stall_cycles_r <= {CNT_W{1'b0}};
    end else if (dm_wait_i) begin
      state_r        <= state_r;
      cnt_r          <= cnt_r;
      stall_cycles_r <= stall_cycles_r;
    end else begin
      case (state_r)
        S_RUN: begin
          if (need_s != 2'd0) begin
            stall_cycles_r <= stall_cycles_r + {{(CNT_W-1){1'b0}}, 1'b1};
            // Stall length is fixed now; the bubble changes the EX fields,
            // so need is not re-evaluated during the stall.
            if (need_s == LOAD_COMP_STALL) begin
              cnt_r   <= 2'd1;
              state_r <= S_STALL;
            end else begin
              state_r <= S_RUN;
            end
          end else begin
            state_r <= S_RUN;
          end
        end
        S_STALL: begin
          stall_cycles_r <= stall_cycles_r + {{(CNT_W-1){1'b0}}, 1'b1};
          cnt_r          <= cnt_r - 2'd1;
          if (cnt_r == 2'd1) begin
            state_r <= S_RUN;
          end else begin
            state_r <= S_STALL;
          end
        end
        default: begin
          state_r <= S_RUN;
          cnt_r   <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: a table of single-cycle
// vectors from S_RUN, then hand-written multi-cycle sequences.
module tb_hazard_stall_ctrl;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic [4:0]       rs1_addr, rs2_addr, rd_ex, rd_me;
  logic             rs1_used, rs2_used, comp, redirect;
  logic             regw_ex, memr_ex, memr_me, dm_wait;
  logic             pc_write, ifid_write, idex_bubble, ifid_flush, freeze;
  logic [CNT_W-1:0] stall_cycles;

  int n_checks;
  int n_fail;

  hazard_stall_ctrl #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .rs1_addr_ID_i  (rs1_addr),
    .rs2_addr_ID_i  (rs2_addr),
    .rs1_used_ID_i  (rs1_used),
    .rs2_used_ID_i  (rs2_used),
    .comp_ID_i      (comp),
    .redirect_ID_i  (redirect),
    .RegWrite_EX_i  (regw_ex),
    .MemRead_EX_i   (memr_ex),
    .rd_addr_EX_i   (rd_ex),
    .MemRead_ME_i   (memr_me),
    .rd_addr_ME_i   (rd_me),
    .dm_wait_i      (dm_wait),
    .PC_write_o     (pc_write),
    .IFID_write_o   (ifid_write),
    .IDEX_bubble_o  (idex_bubble),
    .IFID_flush_o   (ifid_flush),
    .freeze_o       (freeze),
    .stall_cycles_o (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctrl is {PC_write, IFID_write, IDEX_bubble, IFID_flush, freeze}
  typedef struct {
    string      name;
    logic [4:0] rs1, rs2;
    logic       u1, u2, cmp, redir, rw_ex, mr_ex;
    logic [4:0] rdx;
    logic       mr_me;
    logic [4:0] rdm;
    logic       wt;
    logic [4:0] exp_ctrl;
    int         exp_cnt;
  } vec_t;

  vec_t vecs[14];

  task automatic set_idle();
    rs1_addr = 5'd0; rs2_addr = 5'd0; rs1_used = 1'b0; rs2_used = 1'b0;
    comp = 1'b0; redirect = 1'b0; regw_ex = 1'b0; memr_ex = 1'b0;
    rd_ex = 5'd0; memr_me = 1'b0; rd_me = 5'd0; dm_wait = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_idle();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_ctrl(input string name, input logic [4:0] exp);
    logic [4:0] act;
    #1;
    act = {pc_write, ifid_write, idex_bubble, ifid_flush, freeze};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s ctrl: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_cnt(input string name, input int exp);
    n_checks++;
    if (32'(stall_cycles) !== exp) begin
      n_fail++;
      $display("FAIL %s stall_cycles: got %0d expected %0d", name, stall_cycles, exp);
    end
  endtask

  // Load x7 in EX feeding a branch in ID.
  task automatic load_branch_x7(input logic redir);
    set_idle();
    memr_ex = 1'b1; regw_ex = 1'b1; rd_ex = 5'd7;
    rs1_addr = 5'd7; rs1_used = 1'b1; comp = 1'b1; redirect = redir;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    //            name          rs1   rs2   u1 u2 cmp rdr rw mr rdx   mrm rdm  wt  ctrl      cnt
    vecs[0]  = '{"no_hazard",   5'd1, 5'd2, 1, 1, 0, 0, 1, 0, 5'd3, 0, 5'd4, 0, 5'b11000, 0};
    vecs[1]  = '{"ld_use_rs1",  5'd5, 5'd2, 1, 1, 0, 0, 1, 1, 5'd5, 0, 5'd0, 0, 5'b00100, 1};
    vecs[2]  = '{"rs2_unused",  5'd1, 5'd5, 1, 0, 0, 0, 1, 1, 5'd5, 0, 5'd0, 0, 5'b11000, 0};
    vecs[3]  = '{"ld_use_rs2",  5'd1, 5'd5, 1, 1, 0, 0, 1, 1, 5'd5, 0, 5'd0, 0, 5'b00100, 1};
    vecs[4]  = '{"ld_x0",       5'd0, 5'd0, 1, 1, 0, 0, 1, 1, 5'd0, 0, 5'd0, 0, 5'b11000, 0};
    vecs[5]  = '{"alu_fwd",     5'd3, 5'd2, 1, 1, 0, 0, 1, 0, 5'd3, 0, 5'd0, 0, 5'b11000, 0};
    vecs[6]  = '{"alu_comp",    5'd3, 5'd2, 1, 1, 1, 0, 1, 0, 5'd3, 0, 5'd0, 0, 5'b00100, 1};
    vecs[7]  = '{"me_ld_comp",  5'd1, 5'd9, 1, 1, 1, 0, 0, 0, 5'd0, 1, 5'd9, 0, 5'b00100, 1};
    vecs[8]  = '{"me_ld_nocmp", 5'd1, 5'd9, 1, 1, 0, 0, 0, 0, 5'd0, 1, 5'd9, 0, 5'b11000, 0};
    vecs[9]  = '{"redirect",    5'd1, 5'd2, 1, 1, 1, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'b11010, 0};
    vecs[10] = '{"redir_stall", 5'd5, 5'd2, 1, 1, 0, 1, 1, 1, 5'd5, 0, 5'd0, 0, 5'b00100, 1};
    vecs[11] = '{"wait_ld_use", 5'd5, 5'd2, 1, 1, 0, 1, 1, 1, 5'd5, 0, 5'd0, 1, 5'b00001, 0};
    vecs[12] = '{"ld_comp",     5'd6, 5'd7, 1, 1, 1, 0, 1, 1, 5'd7, 0, 5'd0, 0, 5'b00100, 1};
    vecs[13] = '{"me_x0_comp",  5'd0, 5'd2, 1, 1, 1, 0, 0, 0, 5'd0, 1, 5'd0, 0, 5'b11000, 0};

    rst = 1'b1;
    set_idle();
    // Reset state and controls while reset is held.
    tick();
    check_ctrl("during_rst", 5'b11000);
    tick();
    check_cnt("reset_cnt", 0);
    rst = 1'b0;

    // Table: each vector applied for one cycle from a fresh S_RUN.
    for (int i = 0; i < 14; i++) begin
      do_reset();
      rs1_addr = vecs[i].rs1;   rs2_addr = vecs[i].rs2;
      rs1_used = vecs[i].u1;    rs2_used = vecs[i].u2;
      comp     = vecs[i].cmp;   redirect = vecs[i].redir;
      regw_ex  = vecs[i].rw_ex; memr_ex  = vecs[i].mr_ex;
      rd_ex    = vecs[i].rdx;   memr_me  = vecs[i].mr_me;
      rd_me    = vecs[i].rdm;   dm_wait  = vecs[i].wt;
      check_ctrl(vecs[i].name, vecs[i].exp_ctrl);
      tick();
      check_cnt(vecs[i].name, vecs[i].exp_cnt);
    end

    // Load-use: one stall cycle then normal flow.
    do_reset();
    memr_ex = 1'b1; regw_ex = 1'b1; rd_ex = 5'd5; rs1_addr = 5'd5; rs1_used = 1'b1;
    check_ctrl("lu_stall", 5'b00100);
    tick();
    set_idle();
    memr_me = 1'b1; rd_me = 5'd5; rs1_addr = 5'd5; rs1_used = 1'b1;
    check_ctrl("lu_resume", 5'b11000);
    check_cnt("lu_cnt", 1);

    // Load then branch: two stall cycles, redirect suppressed throughout.
    do_reset();
    load_branch_x7(1'b1);
    check_ctrl("lb_stall1", 5'b00100);
    tick();
    set_idle();
    memr_me = 1'b1; rd_me = 5'd7; rs1_addr = 5'd7; rs1_used = 1'b1; comp = 1'b1; redirect = 1'b1;
    check_ctrl("lb_stall2", 5'b00100);
    tick();
    memr_me = 1'b0; rd_me = 5'd0;
    check_ctrl("lb_flush", 5'b11010);
    check_cnt("lb_cnt", 2);

    // ALU producer then JALR: one stall, then the deferred redirect flushes.
    do_reset();
    regw_ex = 1'b1; rd_ex = 5'd3; rs1_addr = 5'd3; rs1_used = 1'b1; comp = 1'b1; redirect = 1'b1;
    check_ctrl("jalr_stall", 5'b00100);
    tick();
    regw_ex = 1'b0; rd_ex = 5'd0;
    check_ctrl("jalr_flush", 5'b11010);
    check_cnt("jalr_cnt", 1);
    tick();
    set_idle();
    check_ctrl("jalr_after", 5'b11000);

    // Wait during the first S_STALL cycle: freeze holds state and counter.
    do_reset();
    load_branch_x7(1'b0);
    tick();
    set_idle();
    memr_me = 1'b1; rd_me = 5'd7; rs1_addr = 5'd7; rs1_used = 1'b1; comp = 1'b1;
    dm_wait = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check_ctrl("wait_freeze", 5'b00001);
      tick();
      check_cnt("wait_hold", 1);
    end
    dm_wait = 1'b0;
    check_ctrl("wait_stall2", 5'b00100);
    tick();
    memr_me = 1'b0; rd_me = 5'd0;
    check_ctrl("wait_resume", 5'b11000);
    check_cnt("wait_total", 2);

    // x0 load feeding a compare never stalls; reset aborts a stall.
    do_reset();
    memr_ex = 1'b1; regw_ex = 1'b1; rd_ex = 5'd0; rs1_used = 1'b1; comp = 1'b1;
    check_ctrl("x0_comp", 5'b11000);
    tick();
    check_cnt("x0_cnt", 0);
    load_branch_x7(1'b0);
    tick();
    rst = 1'b1;
    check_ctrl("rst_in_stall", 5'b11000);
    tick();
    rst = 1'b0;
    set_idle();
    check_ctrl("rst_run", 5'b11000);
    check_cnt("rst_cnt", 0);

    // Counter wraps modulo 2^CNT_W: 17 load-use stalls leave 1.
    do_reset();
    for (int k = 0; k < 17; k++) begin
      memr_ex = 1'b1; regw_ex = 1'b1; rd_ex = 5'd5; rs1_addr = 5'd5; rs1_used = 1'b1;
      tick();
      set_idle();
      tick();
    end
    check_cnt("wrap", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
